washing_machine_prog: RTL and testbench

//  Programmable washing-machine controller; parametrised successor of the single-cycle washer FSM.

---
 rtl/washing_machine_prog.sv | 190 +++++++++++++++++++
 tb/tb_washing_machine_prog.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/washing_machine_prog.sv
// Programmable washer controller: fill/heat/wash/drain, N rinses, spin, with per-phase watchdog, abort and error latch.
// Latency: Moore outputs; an input sampled at a clk50m edge affects state and outputs right after that edge.
// Backpressure: none; sensors are level inputs, start is honoured only in IDLE, ack only in ERR.
module washing_machine_prog #(
    parameter int TMR_W      = 16,
    parameter int FILL_TO    = 1000,
    parameter int HEAT_TO    = 2000,
    parameter int WASH_TO    = 4000,
    parameter int DRAIN_TO   = 1000,
    parameter int SPIN_TO    = 3000,
    parameter int RINSE_TIME = 500,
    parameter int RINSE_W    = 3
) (
    input  logic               clk50m,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               ack,
    input  logic [RINSE_W-1:0] rinse_cnt,
    input  logic               full,
    input  logic               hot,
    input  logic               clean,
    input  logic               dry,
    output logic               door_lock,
    output logic               valve,
    output logic               heater,
    output logic               motor_wash,
    output logic               motor_spin,
    output logic               pump,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [2:0]         err_code,
    output logic [RINSE_W-1:0] rinse_left
);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_HEAT, S_WASH, S_DRAIN, S_RFILL,
        S_RWASH, S_RDRAIN, S_SPIN, S_DONE, S_ABORT, S_ERR
    } state_t;

    // Last legal timer value in each phase; reaching it without the exit condition is a fault.
    localparam logic [TMR_W-1:0] FILL_LAST  = TMR_W'(FILL_TO - 1);
    localparam logic [TMR_W-1:0] HEAT_LAST  = TMR_W'(HEAT_TO - 1);
    localparam logic [TMR_W-1:0] WASH_LAST  = TMR_W'(WASH_TO - 1);
    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TO - 1);
    localparam logic [TMR_W-1:0] SPIN_LAST  = TMR_W'(SPIN_TO - 1);
    localparam logic [TMR_W-1:0] RINSE_LAST = TMR_W'(RINSE_TIME - 1);

    state_t             state;
    state_t             state_nxt;
    state_t             exit_dst;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   to_last;
    logic [RINSE_W-1:0] rinse_left_nxt;
    logic [RINSE_W-1:0] rinse_dec;
    logic [2:0]         err_code_nxt;
    logic [2:0]         to_code;
    logic               exit_ok;
    logic               has_to;
    logic               abortable;

    assign rinse_dec = rinse_left - 1'b1;

    // Next state: each state names its exit condition/destination and watchdog, then abort > exit > timeout.
    always_comb begin
        state_nxt      = state;
        rinse_left_nxt = rinse_left;
        err_code_nxt   = err_code;
        exit_ok        = 1'b0;
        exit_dst       = state;
        has_to         = 1'b0;
        to_last        = '0;
        to_code        = 3'd0;
        abortable      = 1'b1;
        case (state)
            S_IDLE: begin
                abortable = 1'b0;
                if (start) begin
                    state_nxt      = S_FILL;
                    rinse_left_nxt = rinse_cnt;
                end
            end
            S_FILL: begin
                exit_ok = full;   exit_dst = S_HEAT;
                has_to  = 1'b1;   to_last  = FILL_LAST;  to_code = 3'd1;
            end
            S_HEAT: begin
                exit_ok = hot;    exit_dst = S_WASH;
                has_to  = 1'b1;   to_last  = HEAT_LAST;  to_code = 3'd2;
            end
            S_WASH: begin
                exit_ok = clean;  exit_dst = S_DRAIN;
                has_to  = 1'b1;   to_last  = WASH_LAST;  to_code = 3'd3;
            end
            S_DRAIN: begin
                exit_ok  = !full;
                exit_dst = (rinse_left != '0) ? S_RFILL : S_SPIN;
                has_to   = 1'b1;  to_last  = DRAIN_LAST; to_code = 3'd4;
            end
            S_RFILL: begin
                exit_ok = full;   exit_dst = S_RWASH;
                has_to  = 1'b1;   to_last  = FILL_LAST;  to_code = 3'd1;
            end
            S_RWASH: begin
                // Fixed-length agitation, so no watchdog here.
                exit_ok  = (timer == RINSE_LAST);
                exit_dst = S_RDRAIN;
            end
            S_RDRAIN: begin
                exit_ok  = !full;
                exit_dst = (rinse_dec != '0) ? S_RFILL : S_SPIN;
                has_to   = 1'b1;  to_last  = DRAIN_LAST; to_code = 3'd4;
            end
            S_SPIN: begin
                exit_ok = dry;    exit_dst = S_DONE;
                has_to  = 1'b1;   to_last  = SPIN_LAST;  to_code = 3'd5;
            end
            S_DONE: begin
                abortable = 1'b0;
                state_nxt = S_IDLE;
            end
            S_ABORT: begin
                // A held abort must not trap the machine here; the drain just continues.
                abortable = 1'b0;
                exit_ok   = !full;  exit_dst = S_IDLE;
                has_to    = 1'b1;   to_last  = DRAIN_LAST; to_code = 3'd4;
            end
            S_ERR: begin
                abortable = 1'b0;
                if (ack && !full) begin
                    state_nxt    = S_IDLE;
                    err_code_nxt = 3'd0;
                end
            end
            default: begin
                abortable = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase

        if (abortable && abort) begin
            state_nxt = S_ABORT;
        end else if (exit_ok) begin
            state_nxt = exit_dst;
            if (state == S_RDRAIN) rinse_left_nxt = rinse_dec;
        end else if (has_to && timer == to_last) begin
            state_nxt    = S_ERR;
            err_code_nxt = to_code;
        end
    end

    // Actuator/status decode from registered state; ERR keeps the door locked and pump on while water remains.
    always_comb begin
        door_lock  = 1'b0;
        valve      = 1'b0;
        heater     = 1'b0;
        motor_wash = 1'b0;
        motor_spin = 1'b0;
        pump       = 1'b0;
        case (state)
            S_FILL, S_RFILL:           begin door_lock = 1'b1; valve      = 1'b1; end
            S_HEAT:                    begin door_lock = 1'b1; heater     = 1'b1; end
            S_WASH, S_RWASH:           begin door_lock = 1'b1; motor_wash = 1'b1; end
            S_DRAIN, S_RDRAIN, S_ABORT: begin door_lock = 1'b1; pump      = 1'b1; end
            S_SPIN:                    begin door_lock = 1'b1; motor_spin = 1'b1; pump = 1'b1; end
            S_ERR:                     begin door_lock = full; pump       = full; end
            default: ;
        endcase
        busy  = (state != S_IDLE);
        done  = (state == S_DONE);
        error = (state == S_ERR);
    end

    // State, phase timer (cleared on any state change), rinse counter and latched error code.
    always_ff @(posedge clk50m or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            rinse_left <= '0;
            err_code   <= 3'd0;
        end else begin
            state      <= state_nxt;
            timer      <= (state_nxt != state) ? '0 : timer + 1'b1;
            rinse_left <= rinse_left_nxt;
            err_code   <= err_code_nxt;
        end
    end

endmodule

// File: tb/tb_washing_machine_prog.sv
// Bench for washing_machine_prog: directed scenarios plus random sensor/command traffic against a phase-table model.
// Latency: expected outputs are queued when inputs are driven and popped 2ns after the following rising edge.
// Backpressure: none; one queue entry per clock, the monitor consumes every entry.
module tb_washing_machine_prog;

    localparam int RW = 3;

    logic          clk50m = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0, abort = 1'b0, ack = 1'b0;
    logic          full = 1'b0, hot = 1'b0, clean = 1'b0, dry = 1'b0;
    logic [RW-1:0] rinse_cnt = '0;
    logic          door_lock, valve, heater, motor_wash, motor_spin, pump, busy, done, error;
    logic [2:0]    err_code;
    logic [RW-1:0] rinse_left;

    int checks = 0;
    int failures = 0;

    always #10 clk50m = ~clk50m;

    washing_machine_prog dut (
        .clk50m(clk50m), .rst(rst), .start(start), .abort(abort), .ack(ack),
        .rinse_cnt(rinse_cnt), .full(full), .hot(hot), .clean(clean), .dry(dry),
        .door_lock(door_lock), .valve(valve), .heater(heater), .motor_wash(motor_wash),
        .motor_spin(motor_spin), .pump(pump), .busy(busy), .done(done), .error(error),
        .err_code(err_code), .rinse_left(rinse_left)
    );

    typedef struct {
        logic [14:0] vec;
        bit          in_err;
    } exp_t;

    exp_t sbq[$];

    // Reference model: current phase name, cycles spent in it, rinses left, error code.
    string m_phase;
    int    m_tmr, m_rl, m_code;
    int    limit[string];
    int    tcode[string];
    string act[string];

    // Observations gathered by the monitor.
    int       done_seen = 0;
    int       valve_rises = 0;
    logic     valve_d = 1'b0;
    logic [2:0] last_err = 3'd0;

    function automatic logic [14:0] pack_dut();
        return {door_lock, valve, heater, motor_wash, motor_spin, pump,
                busy, done, error, err_code, rinse_left};
    endfunction

    // Expected output word from the phase's actuator letters (L lock, V valve, H heat, W wash, S spin, P pump).
    function automatic logic [14:0] exp_vec(string ph, int rl, int code);
        string a;
        logic [5:0] b;
        a = act[ph];
        b = '0;
        for (int i = 0; i < a.len(); i++) begin
            if (a[i] == "L") b[5] = 1'b1;
            if (a[i] == "V") b[4] = 1'b1;
            if (a[i] == "H") b[3] = 1'b1;
            if (a[i] == "W") b[2] = 1'b1;
            if (a[i] == "S") b[1] = 1'b1;
            if (a[i] == "P") b[0] = 1'b1;
        end
        return {b, (ph != "IDLE"), (ph == "DONE"), (ph == "ERR"), 3'(code), 3'(rl)};
    endfunction

    function automatic void model_reset();
        m_phase = "IDLE";
        m_tmr = 0;
        m_rl = 0;
        m_code = 0;
    endfunction

    function automatic void model_step(logic s, logic a, logic k, int rc,
                                       logic f, logic h, logic c, logic d);
        string nx, dest;
        bit ex;
        nx = m_phase;
        dest = m_phase;
        ex = 1'b0;
        if (m_phase == "IDLE") begin
            if (s) begin nx = "FILL"; m_rl = rc; end
        end else if (m_phase == "DONE") begin
            nx = "IDLE";
        end else if (m_phase == "ERR") begin
            if (k && !f) begin nx = "IDLE"; m_code = 0; end
        end else if (a && m_phase != "ABORT") begin
            nx = "ABORT";
        end else begin
            if (m_phase == "FILL")   begin ex = f;  dest = "HEAT"; end
            if (m_phase == "HEAT")   begin ex = h;  dest = "WASH"; end
            if (m_phase == "WASH")   begin ex = c;  dest = "DRAIN"; end
            if (m_phase == "RFILL")  begin ex = f;  dest = "RWASH"; end
            if (m_phase == "RWASH")  begin ex = (m_tmr == 499); dest = "RDRAIN"; end
            if (m_phase == "SPIN")   begin ex = d;  dest = "DONE"; end
            if (m_phase == "ABORT")  begin ex = !f; dest = "IDLE"; end
            if (m_phase == "DRAIN") begin
                ex = !f;
                if (m_rl > 0) dest = "RFILL"; else dest = "SPIN";
            end
            if (m_phase == "RDRAIN") begin
                ex = !f;
                if (m_rl - 1 > 0) dest = "RFILL"; else dest = "SPIN";
            end
            if (ex) begin
                nx = dest;
                if (m_phase == "RDRAIN") m_rl = m_rl - 1;
            end else if (limit.exists(m_phase) && m_tmr == limit[m_phase] - 1) begin
                nx = "ERR";
                m_code = tcode[m_phase];
            end
        end
        if (nx == m_phase) m_tmr = m_tmr + 1;
        else m_tmr = 0;
        m_phase = nx;
    endfunction

    task automatic step(input logic s, input logic a, input logic k, input int rc,
                        input logic f, input logic h, input logic c, input logic d);
        exp_t e;
        @(negedge clk50m);
        start = s; abort = a; ack = k; rinse_cnt = RW'(rc);
        full = f; hot = h; clean = c; dry = d;
        model_step(s, a, k, rc, f, h, c, d);
        e.vec = exp_vec(m_phase, m_rl, m_code);
        e.in_err = (m_phase == "ERR");
        sbq.push_back(e);
    endtask

    // Drive sensors so the current model phase exits at once.
    task automatic adv(input logic s, input int rc);
        logic f;
        f = !(m_phase == "DRAIN" || m_phase == "RDRAIN" || m_phase == "ABORT" || m_phase == "ERR");
        step(s, 1'b0, 1'b0, rc, f, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic settle();
        @(posedge clk50m);
        #3;
    endtask

    task automatic expect_eq(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d @%0t", name, got, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s cycle budget expired in phase %s", name, m_phase);
    endtask

    task automatic run_prog(input int rc, input int exp_fills);
        int bd, bv, n;
        bd = done_seen;
        bv = valve_rises;
        adv(1'b1, rc);
        n = 0;
        while (m_phase != "IDLE" && n < 6000) begin
            adv(1'b0, 0);
            n++;
        end
        if (m_phase != "IDLE") bound_fail("program_run");
        settle();
        expect_eq("done_pulses", done_seen - bd, 1);
        expect_eq("fill_episodes", valve_rises - bv, exp_fills);
    endtask

    // Monitor: one expected entry per clock, plus the safety invariants on every sampled cycle.
    initial begin : monitor
        exp_t e;
        logic [14:0] ex, got;
        bit bad;
        forever begin
            @(posedge clk50m);
            #2;
            if (!rst && sbq.size() > 0) begin
                e = sbq.pop_front();
                ex = e.vec;
                if (e.in_err) begin
                    ex[14] = full;
                    ex[9]  = full;
                end
                got = pack_dut();
                checks++;
                if (got !== ex) begin
                    failures++;
                    $display("FAIL outputs @%0t got=%h expected=%h (lock,valve,heat,wash,spin,pump,busy,done,err,code,rinse)",
                             $time, got, ex);
                end
                bad = (valve && pump) || (motor_wash && motor_spin) ||
                      (heater && (valve || pump || motor_wash || motor_spin)) ||
                      (!door_lock && busy && !done && !(error && !full));
                checks++;
                if (bad) begin
                    failures++;
                    $display("FAIL safety @%0t outputs=%h full=%b", $time, got, full);
                end
                if (done) done_seen++;
                if (valve && !valve_d) valve_rises++;
                valve_d = valve;
                if (error) last_err = err_code;
            end
        end
    end

    initial begin : main
        int bd, n;
        limit["FILL"] = 1000;  limit["RFILL"] = 1000;  limit["HEAT"] = 2000;
        limit["WASH"] = 4000;  limit["DRAIN"] = 1000;  limit["RDRAIN"] = 1000;
        limit["ABORT"] = 1000; limit["SPIN"] = 3000;
        tcode["FILL"] = 1;  tcode["RFILL"] = 1;  tcode["HEAT"] = 2;  tcode["WASH"] = 3;
        tcode["DRAIN"] = 4; tcode["RDRAIN"] = 4; tcode["ABORT"] = 4; tcode["SPIN"] = 5;
        act["IDLE"] = "";     act["FILL"] = "LV";  act["HEAT"] = "LH";   act["WASH"] = "LW";
        act["DRAIN"] = "LP";  act["RFILL"] = "LV"; act["RWASH"] = "LW";  act["RDRAIN"] = "LP";
        act["SPIN"] = "LSP";  act["DONE"] = "";    act["ABORT"] = "LP";  act["ERR"] = "";
        model_reset();

        // Power-on reset.
        #1 rst = 1'b1;
        #4 expect_eq("reset_outputs", int'(pack_dut()), 0);
        repeat (2) @(negedge clk50m);
        rst = 1'b0;

        // Reset in the middle of WASH clears outputs asynchronously.
        step(1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk50m);
        expect_eq("busy_before_reset", int'(motor_wash), 1);
        #3 rst = 1'b1;
        #1 expect_eq("async_reset_outputs", int'(pack_dut()), 0);
        sbq.delete();
        model_reset();
        repeat (2) @(negedge clk50m);
        rst = 1'b0;

        // Two rinses, then none.
        run_prog(2, 3);
        run_prog(0, 1);

        // HEAT watchdog, ack ignored while full, cleared once drained.
        bd = done_seen;
        adv(1'b1, 1);
        adv(1'b0, 0);
        n = 0;
        while (m_phase == "HEAT" && n < 2100) begin
            step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
            n++;
        end
        if (m_phase != "ERR") bound_fail("heat_timeout");
        repeat (4) step(1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        expect_eq("heat_err_code", int'(last_err), 2);
        expect_eq("heat_err_done", done_seen - bd, 0);

        // Abort in HEAT with water in the drum.
        bd = done_seen;
        adv(1'b1, 2);
        adv(1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        expect_eq("abort_done", done_seen - bd, 0);

        // In DRAIN: start, abort and the drain exit all on one edge.
        bd = done_seen;
        adv(1'b1, 1);
        n = 0;
        while (m_phase != "DRAIN" && n < 20) begin
            adv(1'b0, 0);
            n++;
        end
        if (m_phase != "DRAIN") bound_fail("reach_drain");
        step(1'b1, 1'b1, 1'b0, 5, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        expect_eq("abort_wins_done", done_seen - bd, 0);

        // Random traffic.
        for (int i = 0; i < 12000; i++) begin
            step(($urandom % 8) == 0, ($urandom % 250) == 0, ($urandom % 4) == 0,
                 $urandom_range(0, 3), ($urandom % 2) == 0, ($urandom % 4) == 0,
                 ($urandom % 4) == 0, ($urandom % 4) == 0);
        end
        settle();
        expect_eq("scoreboard_drained", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
